// File: rtl/if_prefetch_if.sv
// Instruction memory request/response bus for the fetch prefetcher.
// master: prefetcher (issues addresses, takes responses); slave: memory.
interface if_prefetch_if #(
    parameter int XLEN = 32
);
    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_addr;
    logic            imem_rsp_valid;
    logic [XLEN-1:0] imem_rsp_data;

    modport master (
        output imem_req_valid,
        output imem_addr,
        input  imem_req_ready,
        input  imem_rsp_valid,
        input  imem_rsp_data
    );

    modport slave (
        input  imem_req_valid,
        input  imem_addr,
        output imem_req_ready,
        output imem_rsp_valid,
        output imem_rsp_data
    );
endinterface

// File: rtl/if_prefetch.sv
// Fetch-stage prefetcher: credit-limited in-order requests into a FIFO.
// Ports: clk/rst, jump_*_id redirect, imem bus (master), inst_* to ID.
module if_prefetch #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              DEPTH    = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            jump_flag_id,
    input  logic [XLEN-1:0] jump_address_id,
    if_prefetch_if.master   imem,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] inst_data,
    output logic [XLEN-1:0] inst_pc
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [CW-1:0]   occ, outst, drop;
    logic [CW-1:0]   occ_n, outst_n, drop_n;
    logic [AW-1:0]   rd_ptr, wr_ptr;
    logic [XLEN-1:0] fetch_pc, rsp_pc;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] data_q [DEPTH];
    logic [XLEN-1:0] pc_q   [DEPTH];
    logic [CW:0]     used;
    logic            credit, issue, push, pop, has_drop;

    // Credits count buffered plus in-flight words, so a push can
    // never find the buffer full.
    assign used     = {1'b0, occ} + {1'b0, outst};
    assign credit   = used < (CW + 1)'(DEPTH);
    assign has_drop = drop != '0;
    assign target   = jump_address_id & ~XLEN'(3);

    assign imem.imem_req_valid = ~rst & credit & ~jump_flag_id;
    assign imem.imem_addr      = fetch_pc;

    assign issue = imem.imem_req_valid & imem.imem_req_ready;
    assign push  = imem.imem_rsp_valid & ~has_drop & ~jump_flag_id;
    assign pop   = inst_valid & inst_ready & ~jump_flag_id;

    assign inst_valid = occ != '0;
    assign inst_data  = data_q[rd_ptr];
    assign inst_pc    = pc_q[rd_ptr];

    always_comb begin
        occ_n   = occ + CW'(push) - CW'(pop);
        outst_n = outst + CW'(issue) - CW'(imem.imem_rsp_valid);
        drop_n  = drop - CW'(imem.imem_rsp_valid & has_drop);
        if (jump_flag_id) begin
            occ_n  = '0;
            // outst already includes older drops, so after a redirect
            // every request still in flight is a drop.
            drop_n = outst_n;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ      <= '0;
            outst    <= '0;
            drop     <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            fetch_pc <= RESET_PC;
            rsp_pc   <= RESET_PC;
        end else begin
            occ   <= occ_n;
            outst <= outst_n;
            drop  <= drop_n;
            if (jump_flag_id) begin
                fetch_pc <= target;
                rsp_pc   <= target;
                rd_ptr   <= '0;
                wr_ptr   <= '0;
            end else begin
                if (issue) fetch_pc <= fetch_pc + XLEN'(4);
                if (push) begin
                    rsp_pc <= rsp_pc + XLEN'(4);
                    wr_ptr <= wr_ptr + AW'(1);
                end
                if (pop) rd_ptr <= rd_ptr + AW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            data_q[wr_ptr] <= imem.imem_rsp_data;
            pc_q[wr_ptr]   <= rsp_pc;
        end
    end
endmodule

// File: tb/tb_if_prefetch.sv
// Directed bench for if_prefetch with a resettable in-order memory
// model of 1 or 3 cycles latency that returns the address as data.
module tb_if_prefetch;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        jump_flag_id = 1'b0;
    logic [31:0] jump_address_id = '0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        mem_ready = 1'b1;

    int n_cmp = 0;
    int n_bad = 0;
    int lat = 1;

    if_prefetch_if #(.XLEN(32)) bus ();

    if_prefetch #(.XLEN(32), .RESET_PC(32'h0), .DEPTH(4)) dut (
        .clk             (clk),
        .rst             (rst),
        .jump_flag_id    (jump_flag_id),
        .jump_address_id (jump_address_id),
        .imem            (bus),
        .inst_valid      (inst_valid),
        .inst_ready      (inst_ready),
        .inst_data       (inst_data),
        .inst_pc         (inst_pc)
    );

    always #5 clk = ~clk;

    logic [2:0]  pv;
    logic [31:0] pd [3];
    logic        hs;

    assign hs = bus.imem_req_valid & bus.imem_req_ready;
    assign bus.imem_req_ready = mem_ready;
    assign bus.imem_rsp_valid = pv[0];
    assign bus.imem_rsp_data  = pd[0];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            pv <= '0;
            pd[0] <= '0;
            pd[1] <= '0;
            pd[2] <= '0;
        end else begin
            pv    <= {1'b0, pv[2:1]};
            pd[0] <= pd[1];
            pd[1] <= pd[2];
            if (hs) begin
                pv[lat-1] <= 1'b1;
                pd[lat-1] <= bus.imem_addr;
            end
        end
    end

    typedef struct {
        logic        rdy;
        logic        jmp;
        logic [31:0] ja;
        logic        e_rv;
        logic [31:0] e_addr;
        logic        e_iv;
        logic [31:0] e_pc;
    } vec_t;

    vec_t vt [26];

    task automatic setv(input int i, input logic rdy, input logic jmp,
                        input logic [31:0] ja, input logic rv,
                        input logic [31:0] a, input logic iv,
                        input logic [31:0] pc);
        vt[i].rdy = rdy;  vt[i].jmp = jmp;  vt[i].ja = ja;
        vt[i].e_rv = rv;  vt[i].e_addr = a;
        vt[i].e_iv = iv;  vt[i].e_pc = pc;
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Leaves the bench just after a falling edge with rst released.
    task automatic do_reset(input int l);
        rst = 1'b1;
        jump_flag_id = 1'b0;
        inst_ready = 1'b0;
        lat = l;
        repeat (2) @(negedge clk);
        #1;
        chk("rst req_valid", 32'(bus.imem_req_valid), 32'd0);
        chk("rst inst_valid", 32'(inst_valid), 32'd0);
        chk("rst imem_addr", bus.imem_addr, 32'h0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Steps until the head is valid (bounded), then checks pc and data.
    task automatic wait_head(input string nm, input logic [31:0] pc);
        int k;
        k = 0;
        while (!inst_valid && k < 20) begin
            @(negedge clk);
            #1;
            k++;
        end
        if (!inst_valid) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: got no inst_valid expected pc %h", nm, pc);
        end else begin
            chk({nm, " pc"}, inst_pc, pc);
            chk({nm, " data"}, inst_data, pc);
        end
    endtask

    task automatic next_cyc();
        @(negedge clk);
        #1;
    endtask

    initial begin
        setv(0,  1, 0, 0, 1, 32'h00, 0, 0);
        setv(1,  1, 0, 0, 1, 32'h04, 0, 0);
        setv(2,  1, 0, 0, 1, 32'h08, 1, 32'h00);
        setv(3,  1, 0, 0, 1, 32'h0c, 1, 32'h04);
        setv(4,  1, 0, 0, 1, 32'h10, 1, 32'h08);
        setv(5,  1, 0, 0, 1, 32'h14, 1, 32'h0c);
        setv(6,  0, 0, 0, 1, 32'h18, 1, 32'h10);
        setv(7,  0, 0, 0, 1, 32'h1c, 1, 32'h10);
        for (int i = 8; i < 16; i++)
            setv(i, 0, 0, 0, 0, 32'h20, 1, 32'h10);
        setv(16, 1, 0, 0, 0, 32'h20, 1, 32'h10);
        setv(17, 1, 0, 0, 1, 32'h20, 1, 32'h14);
        setv(18, 1, 0, 0, 1, 32'h24, 1, 32'h18);
        setv(19, 1, 0, 0, 1, 32'h28, 1, 32'h1c);
        setv(20, 1, 0, 0, 1, 32'h2c, 1, 32'h20);
        setv(21, 1, 1, 32'h203, 0, 32'h30, 1, 32'h24);
        setv(22, 1, 0, 0, 1, 32'h200, 0, 0);
        setv(23, 1, 0, 0, 1, 32'h204, 0, 0);
        setv(24, 1, 0, 0, 1, 32'h208, 1, 32'h200);
        setv(25, 1, 0, 0, 1, 32'h20c, 1, 32'h204);

        // Streaming, stall to full, release, redirect under pop+rsp.
        do_reset(1);
        for (int i = 0; i < 26; i++) begin
            inst_ready = vt[i].rdy;
            jump_flag_id = vt[i].jmp;
            jump_address_id = vt[i].ja;
            #1;
            chk($sformatf("v%0d req_valid", i),
                32'(bus.imem_req_valid), 32'(vt[i].e_rv));
            chk($sformatf("v%0d imem_addr", i), bus.imem_addr, vt[i].e_addr);
            chk($sformatf("v%0d inst_valid", i),
                32'(inst_valid), 32'(vt[i].e_iv));
            if (vt[i].e_iv) begin
                chk($sformatf("v%0d inst_pc", i), inst_pc, vt[i].e_pc);
                chk($sformatf("v%0d inst_data", i), inst_data, vt[i].e_pc);
            end
            @(negedge clk);
        end
        jump_flag_id = 1'b0;

        // 3-cycle memory, redirect with two requests in flight.
        do_reset(3);
        inst_ready = 1'b1;
        #1;
        chk("j1 addr0", bus.imem_addr, 32'h0);
        next_cyc();
        chk("j1 addr1", bus.imem_addr, 32'h4);
        @(negedge clk);
        jump_flag_id = 1'b1;
        jump_address_id = 32'h100;
        #1;
        chk("j1 no req in jump", 32'(bus.imem_req_valid), 32'd0);
        @(negedge clk);
        jump_flag_id = 1'b0;
        #1;
        chk("j1 first req", bus.imem_addr, 32'h100);
        wait_head("j1 head0", 32'h100);
        next_cyc();
        chk("j1 head1 pc", inst_pc, 32'h104);

        // Back-to-back redirects; second one sees a response arrive.
        do_reset(3);
        inst_ready = 1'b1;
        repeat (2) @(negedge clk);
        jump_flag_id = 1'b1;
        jump_address_id = 32'h80;
        @(negedge clk);
        jump_address_id = 32'h100;
        #1;
        chk("j2 no req in jump", 32'(bus.imem_req_valid), 32'd0);
        @(negedge clk);
        jump_flag_id = 1'b0;
        #1;
        chk("j2 first req", bus.imem_addr, 32'h100);
        wait_head("j2 head0", 32'h100);
        next_cyc();
        chk("j2 head1 pc", inst_pc, 32'h104);

        // Address wrap at the top of the space.
        do_reset(1);
        inst_ready = 1'b1;
        jump_flag_id = 1'b1;
        jump_address_id = 32'hffff_fffe;
        @(negedge clk);
        jump_flag_id = 1'b0;
        #1;
        chk("wrap req0", bus.imem_addr, 32'hffff_fffc);
        next_cyc();
        chk("wrap req1", bus.imem_addr, 32'h0);
        wait_head("wrap head0", 32'hffff_fffc);
        next_cyc();
        chk("wrap head1 pc", inst_pc, 32'h0);

        // Asynchronous reset with buffered and in-flight words.
        do_reset(3);
        repeat (5) @(negedge clk);
        #1;
        chk("mid inst_valid", 32'(inst_valid), 32'd1);
        chk("mid inst_pc", inst_pc, 32'h0);
        #1;
        rst = 1'b1;
        #1;
        chk("async req_valid", 32'(bus.imem_req_valid), 32'd0);
        chk("async inst_valid", 32'(inst_valid), 32'd0);
        chk("async imem_addr", bus.imem_addr, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        inst_ready = 1'b1;
        #1;
        chk("restart req_valid", 32'(bus.imem_req_valid), 32'd1);
        chk("restart addr", bus.imem_addr, 32'h0);
        wait_head("restart head0", 32'h0);
        next_cyc();
        chk("restart head1 pc", inst_pc, 32'h4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule
